// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO feeding a UART transmitter one load pulse at a time, paced by tx_empty.
// Optional macro UART_TXF_FLUSH_EN adds a flush input that empties the FIFO in one edge.
module uart_tx_feeder #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              txclk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              wr_ready,
    input  logic              clr_ovf,
    output logic              overflow,
    output logic [ADDR_W:0]   fifo_count,
`ifdef UART_TXF_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              tx_empty,
    output logic              ld_tx_data,
    output logic [7:0]        tx_data
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wr_ready_q, wr_ready_d;
    logic              overflow_q, overflow_d;
    logic              ld_q, ld_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [7:0]        mem_q [DEPTH];

    logic flush_c;
    logic full_c;
    logic push_c;
    logic pop_c;

`ifdef UART_TXF_FLUSH_EN
    assign flush_c = flush;
`else
    assign flush_c = 1'b0;
`endif

    // Full is judged on the pre-edge count, so a same-cycle pop never admits a write at full.
    assign full_c = (count_q == FULL_CNT);
    assign push_c = wr_en && !full_c && !flush_c;
    assign pop_c  = (state_q == IDLE) && (count_q != '0) && tx_empty && !flush_c;

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        ld_d       = 1'b0;
        tx_data_d  = tx_data_q;

        case (state_q)
            IDLE: begin
                if (pop_c) begin
                    tx_data_d = mem_q[rd_ptr_q];
                    ld_d      = 1'b1;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                // Hold off until the transmitter acknowledges the load by dropping tx_empty.
                if (!tx_empty) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (push_c && !pop_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_c && !push_c) begin
            count_d = count_q - CNT_W'(1);
        end

        if (flush_c) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else if (wr_en && full_c) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end

        wr_ready_d = (count_d != FULL_CNT);
    end

    always_ff @(posedge txclk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            wr_ready_q <= 1'b1;
            overflow_q <= 1'b0;
            ld_q       <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            wr_ready_q <= wr_ready_d;
            overflow_q <= overflow_d;
            ld_q       <= ld_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge txclk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign wr_ready   = wr_ready_q;
    assign overflow   = overflow_q;
    assign fifo_count = count_q;
    assign ld_tx_data = ld_q;
    assign tx_data    = tx_data_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: queue-based reference model, a simple transmitter model and directed tests.
module tb_uart_tx_feeder;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;

    logic              txclk = 1'b0;
    logic              reset_n;
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              wr_ready;
    logic              clr_ovf;
    logic              overflow;
    logic [ADDR_W:0]   fifo_count;
    logic              flush;
    logic              tx_empty = 1'b1;
    logic              ld_tx_data;
    logic [7:0]        tx_data;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .txclk      (txclk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .clr_ovf    (clr_ovf),
        .overflow   (overflow),
        .fifo_count (fifo_count),
`ifdef UART_TXF_FLUSH_EN
        .flush      (flush),
`endif
        .tx_empty   (tx_empty),
        .ld_tx_data (ld_tx_data),
        .tx_data    (tx_data)
    );

    always #5 txclk = ~txclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a byte queue, a sticky overflow bit and an "awaiting acknowledge" flag.
    logic [7:0] mq[$];
    logic       m_ovf  = 1'b0;
    logic       m_ld   = 1'b0;
    logic [7:0] m_txd  = 8'h00;
    bit         m_wait = 1'b0;
    bit         m_full;
    bit         m_load;

    initial forever begin
        @(posedge txclk);
        cyc++;
        if (!reset_n) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_ld   = 1'b0;
            m_txd  = 8'h00;
            m_wait = 1'b0;
        end else begin
            m_full = (mq.size() == int'(DEPTH));
            m_load = !m_wait && (mq.size() != 0) && tx_empty && !flush;
            if (m_wait && !tx_empty) m_wait = 1'b0;
            m_ld = m_load;
            if (m_load) begin
                m_txd  = mq.pop_front();
                m_wait = 1'b1;
            end
            if (flush) begin
                mq.delete();
            end else begin
                if (wr_en && !m_full) mq.push_back(wr_data);
                if (wr_en && m_full) m_ovf = 1'b1;
                else if (clr_ovf) m_ovf = 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge txclk);
        if (chk_en) begin
            check("fifo_count", 32'(fifo_count), 32'(mq.size()));
            check("wr_ready",   32'(wr_ready),   32'(mq.size() != int'(DEPTH)));
            check("overflow",   32'(overflow),   32'(m_ovf));
            check("ld_tx_data", 32'(ld_tx_data), 32'(m_ld));
            check("tx_data",    32'(tx_data),    32'(m_txd));
        end
    end

    // Pulse log and the transmitter's view of the load strobe.
    logic [7:0] log_d[$];
    int         log_c[$];
    logic       ld_prev = 1'b0;

    initial forever begin
        @(negedge txclk);
        ld_prev = ld_tx_data;
        if (ld_tx_data === 1'b1) begin
            log_d.push_back(tx_data);
            log_c.push_back(cyc);
        end
    end

    // Transmitter model: busy for busy_len edges after taking a byte.
    int busy     = 0;
    int busy_len = 10;
    bit tx_hold  = 1'b0;
    bit tx_deaf  = 1'b0;

    initial forever begin
        @(posedge txclk);
        #2;
        if (ld_prev === 1'b1 && !tx_deaf) busy = busy_len;
        else if (busy != 0) busy--;
        tx_empty = (busy == 0) && !tx_hold;
    end

    task automatic tick();
        @(posedge txclk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_pulses(input int n, input int budget, input string name);
        int k = 0;
        while (log_d.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(name, 32'(log_d.size()), 32'(n));
    endtask

    task automatic clear_log();
        log_d.delete();
        log_c.delete();
    endtask

    logic [7:0] exp_q[$];
    int         wcyc;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        clr_ovf = 1'b0;
        flush   = 1'b0;

        // Reset held for two edges.
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_wr_ready", 32'(wr_ready),   32'h1);
        check("rst_count",    32'(fifo_count), 32'h0);
        check("rst_ld",       32'(ld_tx_data), 32'h0);
        check("rst_tx_data",  32'(tx_data),    32'h00);
        check("rst_overflow", 32'(overflow),   32'h0);
        reset_n = 1'b1;
        tick();

        // Single byte: pulse one edge after the edge that took the write.
        clear_log();
        push_byte(8'hA5);
        wcyc = cyc;
        wait_pulses(1, 20, "t2_pulse_seen");
        repeat (30) tick();
        check("t2_pulse_count", 32'(log_d.size()), 32'd1);
        check("t2_data",        32'(log_d[0]),     32'hA5);
        check("t2_latency",     32'(log_c[0] - wcyc), 32'd1);
        check("t2_count_zero",  32'(fifo_count),   32'd0);

        // Burst of three with a 10-cycle busy transmitter.
        clear_log();
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        wait_pulses(3, 200, "t3_pulses_seen");
        repeat (20) tick();
        check("t3_pulse_count", 32'(log_d.size()), 32'd3);
        check("t3_data0", 32'(log_d[0]), 32'h11);
        check("t3_data1", 32'(log_d[1]), 32'h22);
        check("t3_data2", 32'(log_d[2]), 32'h33);
        for (int i = 1; i < 3; i++) begin
            check("t3_gap_ge_11", 32'((log_c[i] - log_c[i-1]) >= 11), 32'd1);
        end

        // Fill to full with the transmitter stalled, overflow, clear, drain.
        tx_hold = 1'b1;
        tick();
        clear_log();
        for (int i = 0; i < 16; i++) push_byte(8'(8'h40 + i));
        check("t4_count_full",   32'(fifo_count), 32'd16);
        check("t4_wr_ready_low", 32'(wr_ready),   32'd0);
        push_byte(8'hEE);
        check("t4_overflow_set", 32'(overflow),   32'd1);
        check("t4_count_held",   32'(fifo_count), 32'd16);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("t4_overflow_clr", 32'(overflow),   32'd0);
        busy_len = 2;
        tx_hold  = 1'b0;
        wait_pulses(16, 300, "t4_drain_seen");
        repeat (10) tick();
        check("t4_drain_count", 32'(log_d.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check("t4_drain_data", 32'(log_d[i]), 32'(8'h40 + i));
        end
        check("t4_empty", 32'(fifo_count), 32'd0);

        // Push during a pop at count 5, then a push at full during a pop.
        tx_hold = 1'b1;
        tick();
        clear_log();
        for (int i = 0; i < 5; i++) push_byte(8'(8'h50 + i));
        tx_hold = 1'b0;
        wr_en   = 1'b1;
        wr_data = 8'h55;
        tick();
        wr_en   = 1'b0;
        tx_hold = 1'b1;
        check("t5_count_stays_5", 32'(fifo_count), 32'd5);
        check("t5_pop_pulse",     32'(ld_tx_data), 32'd1);
        check("t5_pop_data",      32'(tx_data),    32'h50);
        tick();
        for (int i = 0; i < 11; i++) push_byte(8'(8'h60 + i));
        check("t5_count_full", 32'(fifo_count), 32'd16);
        tx_hold = 1'b0;
        wr_en   = 1'b1;
        wr_data = 8'h99;
        tick();
        wr_en   = 1'b0;
        check("t5_full_push_rejected", 32'(fifo_count), 32'd15);
        check("t5_full_push_ovf",      32'(overflow),   32'd1);
        check("t5_full_pop_pulse",     32'(ld_tx_data), 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 6; i++)  exp_q.push_back(8'(8'h50 + i));
        for (int i = 0; i < 11; i++) exp_q.push_back(8'(8'h60 + i));
        wait_pulses(17, 400, "t5_drain_seen");
        repeat (10) tick();
        for (int i = 0; i < 17; i++) begin
            check("t5_drain_data", 32'(log_d[i]), 32'(exp_q[i]));
        end

        // Reset while waiting on a transmitter that never acknowledges.
        tx_deaf = 1'b1;
        tick();
        clear_log();
        for (int i = 0; i < 5; i++) push_byte(8'(8'h80 + i));
        repeat (10) tick();
        check("t6_count_4",     32'(fifo_count),   32'd4);
        check("t6_one_pulse",   32'(log_d.size()), 32'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("t6_count_reset", 32'(fifo_count), 32'd0);
        check("t6_ld_reset",    32'(ld_tx_data), 32'd0);
        repeat (30) tick();
        check("t6_no_more_pulses", 32'(log_d.size()), 32'd1);
        tx_deaf = 1'b0;
        repeat (5) tick();

`ifdef UART_TXF_FLUSH_EN
        // Flush with eight queued; the same-cycle write is discarded.
        tx_hold = 1'b1;
        tick();
        clear_log();
        for (int i = 0; i < 8; i++) push_byte(8'(8'hC0 + i));
        check("t7_count_8", 32'(fifo_count), 32'd8);
        flush   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h77;
        tick();
        flush   = 1'b0;
        wr_en   = 1'b0;
        check("t7_flush_count",    32'(fifo_count), 32'd0);
        check("t7_flush_wr_ready", 32'(wr_ready),   32'd1);
        check("t7_flush_no_ovf",   32'(overflow),   32'd0);
        tx_hold = 1'b0;
        repeat (30) tick();
        check("t7_no_pulses", 32'(log_d.size()), 32'd0);
`endif

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
